// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the ADC sampler.
// FSM encodings, converter width/offset and sample conversion helper.
package adc_sampler_pkg;

  localparam int ADC_WIDTH  = 10;
  localparam int ADC_OFFSET = 512;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CONV = 2'd2
  } state_e;

  // Offset-binary to two's complement; equals {~raw[9], raw[8:0]}.
  function automatic logic [ADC_WIDTH-1:0] to_signed(
    input logic [ADC_WIDTH-1:0] raw
  );
    return raw - ADC_WIDTH'(ADC_OFFSET);
  endfunction

endpackage

// File: rtl/adc_sampler_fifo.sv
// sample_fifo: synchronous FIFO with flop storage and occupancy count.
// Ports: clk, rst_n, push_i/data_i, pop_i, data_o (head), full_o, empty_o, level_o.
module sample_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE    = AW'(1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + L_ONE;
      2'b01:   level_d = level_q - L_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + P_ONE;
      end
      if (do_pop) begin
        rd_q <= rd_q + P_ONE;
      end
      level_q <= level_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: periodic SPI-ADC trigger, sample capture and stream FIFO.
// Ports: clk/rst_n, run, adc_enable/adc_clear_available, adc_data/adc_available,
// m_data/m_valid/m_ready, fifo_level, overrun/overrun_clr.
// Optional ADC_SAMPLER_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SAMPLE_FREQ = 45_000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  output logic                        adc_enable,
  output logic                        adc_clear_available,
  input  logic [ADC_WIDTH-1:0]        adc_data,
  input  logic                        adc_available,
  output logic [ADC_WIDTH-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        overrun_clr,
`ifdef ADC_SAMPLER_OVERRUN_CNT_EN
  output logic [15:0]                 overrun_cnt,
`endif
  output logic                        overrun
);

  localparam int PERIOD = CLK_FREQ / SAMPLE_FREQ;
  localparam int CW     = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  state_e         state_q;
  state_e         state_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [1:0]     age_q;
  logic [1:0]     age_d;
  logic           overrun_q;
  logic           overrun_d;
  logic           tick;
  logic           push;
  logic           tick_ovr;
  logic           drop;
  logic           fifo_full;
  logic           fifo_empty;

  assign tick = run & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + C_ONE;
    if (!run || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    state_d             = state_q;
    age_d               = age_q;
    adc_enable          = 1'b0;
    adc_clear_available = 1'b0;
    push                = 1'b0;
    tick_ovr            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (tick) begin
          state_d             = S_CONV;
          adc_enable          = 1'b1;
          adc_clear_available = 1'b1;
          age_d               = '0;
        end
      end
      S_CONV: begin
        tick_ovr = tick;
        // The available flag may still be stale for two cycles
        // while the converter processes the clear.
        if (age_q != 2'd2) age_d = age_q + 2'd1;
        if (age_q == 2'd2 && adc_available) begin
          push    = 1'b1;
          state_d = run ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drop      = push & fifo_full & ~m_ready;
  assign overrun_d = (overrun_q & ~overrun_clr) | tick_ovr | drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      age_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      age_q     <= age_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

`ifdef ADC_SAMPLER_OVERRUN_CNT_EN
  logic [15:0] ocnt_q;
  logic [15:0] ocnt_d;
  logic [16:0] ocnt_sum;

  always_comb begin
    ocnt_sum = {1'b0, (overrun_clr ? 16'd0 : ocnt_q)}
             + 17'(tick_ovr) + 17'(drop);
    ocnt_d   = ocnt_sum[16] ? 16'hFFFF : ocnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ocnt_q <= '0;
    else        ocnt_q <= ocnt_d;
  end

  assign overrun_cnt = ocnt_q;
`endif

  sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (ADC_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (to_signed(adc_data)),
    .pop_i  (m_ready),
    .data_o (m_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  assign m_valid = ~fifo_empty;

endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 Parameter CLK_FREQ, default 27_000_000, system clock frequency in Hz.
REQ-002 Parameter SAMPLE_FREQ, default 45_000, sample trigger rate in Hz; SAMPLE_PERIOD = CLK_FREQ/SAMPLE_FREQ (600 at defaults), exact division required.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two; LEVEL_W = log2(FIFO_DEPTH)+1.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 run  input  1  level; 1 = periodic sampling enabled.
REQ-007 adc_enable  output  1  one-cycle conversion-start pulse to the SPI ADC converter.
REQ-008 adc_clear_available  output  1  one-cycle pulse clearing the converter's available flag.
REQ-009 adc_data  input  10  unsigned conversion result from the converter.
REQ-010 adc_available  input  1  converter result-valid flag (level, sticky until cleared).
REQ-011 m_data  output  10  signed two's-complement sample (adc_data - 512).
REQ-012 m_valid / m_ready  output / input  1 / 1  stream handshake; transfer when both high on a clk edge.
REQ-013 fifo_level  output  LEVEL_W  current FIFO occupancy.
REQ-014 overrun  output  1  sticky error flag; overrun_clr  input  1  clears it.

Function
REQ-015 Tick counter counts 0..SAMPLE_PERIOD-1 while run=1, held at 0 while run=0; tick = counter at SAMPLE_PERIOD-1, first tick SAMPLE_PERIOD cycles after run rises.
REQ-016 FSM states S_IDLE, S_WAIT, S_CONV; S_IDLE->S_WAIT when run=1; S_WAIT->S_CONV on tick, asserting adc_enable and adc_clear_available together for exactly that cycle; S_WAIT->S_IDLE when run=0.
REQ-017 S_CONV ignores adc_available in its entry cycle and the cycle after (flag-clear latency); thereafter adc_available=1 captures adc_data, pushes {~adc_data[9], adc_data[8:0]} to FIFO, returns to S_WAIT (S_IDLE if run=0).
REQ-018 run falling during S_CONV: conversion completes and its sample is pushed; no further adc_enable.
REQ-019 Tick arriving while in S_CONV: no adc_enable issued, overrun set.
REQ-020 Push while FIFO full and m_ready=0: sample dropped, overrun set, contents unchanged.
REQ-021 Push while full and m_ready=1 same cycle: pop and push both occur, level unchanged, no overrun.
REQ-022 m_valid = level!=0; m_data is head entry, registered; pushed sample visible on m_data/m_valid one cycle after capture edge; no bypass when empty.
REQ-023 Pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH.
REQ-024 overrun_clr and a new overrun event in same cycle: overrun stays 1.

Reset
REQ-025 rst_n low: state S_IDLE, tick counter 0, FIFO empty, adc_enable=0, adc_clear_available=0, m_valid=0, m_data=0, fifo_level=0, overrun=0; reset mid-conversion discards the pending sample.

Configuration
REQ-026 Macro ADC_SAMPLER_OVERRUN_CNT_EN defined: extra output overrun_cnt [15:0], +1 per overrun event, saturating at 16'hFFFF, cleared by overrun_clr and reset; undefined: port and counter absent, all else identical.

Structure
REQ-027 Shared package holds FSM state encodings, ADC_OFFSET=512 and ADC_WIDTH=10 constants.
REQ-028 One sub-module, sample_fifo (synchronous FIFO, parameter FIFO_DEPTH, push/pop/full/empty/level); FSM and tick logic stay in adc_sampler.

Verification
REQ-029 run=1, ADC model returns 10'h3FF after 481 cycles -> adc_enable at cycle 600, m_data=10'h1FF, m_valid one cycle after available.
REQ-030 ADC returns 10'h000 then 10'h200 -> m_data 10'h200 (-512) then 10'h000, in order.
REQ-031 m_ready=0, 17 conversions -> fifo_level=16, 17th dropped, overrun=1; m_ready=1 drains first 16 in order.
REQ-032 ADC model latency 700 cycles (> period) -> tick at 1200 skipped, overrun=1, next adc_enable at 1800.
REQ-033 run dropped 100 cycles after adc_enable -> sample still pushed, no further adc_enable; rst_n pulse mid-conversion -> all outputs at reset values, no push.
REQ-034 Full FIFO with m_ready=1 and push same cycle -> level stays 16, overrun=0; with ADC_SAMPLER_OVERRUN_CNT_EN, 3 overruns -> overrun_cnt=3, overrun_clr -> 0.
